leddc_serial_tx: RTL and testbench

//  Upstream feeder for the LED display controller: accepts 16-bit gray-level words over a

---
 rtl/leddc_serial_tx_if.sv | 35 +++
 rtl/leddc_serial_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_leddc_serial_tx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leddc_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : leddc_serial_tx_if
// Description : Bundles the gray-word feed (valid/ready), the enable control
//               and the serial/status outputs of leddc_serial_tx.
//               master : source/observer side (drives data, valid, enable)
//               slave  : serialiser side (drives ready, DAI, DEN, status)
// Signals     : pix_data[WORD_W], pix_valid, pix_ready, enable,
//               DAI, DEN, frame_done, underrun, word_cnt[10]
// Revision    : 1.0 - initial release
// ============================================================================
interface leddc_serial_tx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              enable;
    logic              DAI;
    logic              DEN;
    logic              frame_done;
    logic              underrun;
    logic [9:0]        word_cnt;

    modport master (
        output pix_data, pix_valid, enable,
        input  pix_ready, DAI, DEN, frame_done, underrun, word_cnt
    );

    modport slave (
        input  pix_data, pix_valid, enable,
        output pix_ready, DAI, DEN, frame_done, underrun, word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/leddc_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : leddc_serial_tx
// Description : Upstream feeder for the LED display controller. Buffers
//               gray words in a small FIFO and serialises them LSB-first on
//               DAI, framed by DEN (high for exactly WORD_W DCK cycles per
//               word). After FRAME_WORDS words, DEN is held low for
//               FRAME_GAP cycles of blanking.
// Ports       : DCK        - serial data clock, all logic on rising edge
//               rst_n      - synchronous reset, active low
//               bus        - slave modport: pix_data/pix_valid/pix_ready feed,
//                            enable, DAI, DEN, frame_done, underrun, word_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module leddc_serial_tx #(
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 512,
    parameter int FRAME_GAP   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic         DCK,
    input  wire logic         rst_n,
    leddc_serial_tx_if.slave  bus
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int c_GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int c_SW = WORD_W - 1;

    localparam logic [c_AW:0]   c_DEPTH     = FIFO_DEPTH[c_AW:0];
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(WORD_W - 1);
    localparam logic [c_BW-1:0] c_BIT_PEN   = c_BW'(WORD_W - 2);
    localparam logic [9:0]      c_WORD_LAST = 10'(FRAME_WORDS - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_head;

    assign w_full        = (r_count == c_DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_head        = r_mem[r_rd_ptr];
    // Held low during reset so no word is accepted into a FIFO being cleared.
    assign bus.pix_ready = rst_n & ~w_full;
    assign w_push        = bus.pix_valid & bus.pix_ready;

    always_ff @(posedge DCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.pix_data;
        end
    end

    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    // Bits still to be sent after the one currently on DAI.
    logic [c_SW-1:0]   r_shift;
    logic [c_SW-1:0]   w_shift_nxt;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [c_BW-1:0]   w_bit_cnt_nxt;
    logic [9:0]        r_word_cnt;
    logic [9:0]        w_word_cnt_nxt;
    logic [c_GW-1:0]   r_gap_cnt;
    logic [c_GW-1:0]   w_gap_cnt_nxt;
    logic              r_dai;
    logic              w_dai_nxt;
    logic              r_den;
    logic              w_den_nxt;
    logic              r_frame_done;
    logic              w_frame_done_nxt;
    logic              r_underrun;
    logic              w_underrun_nxt;
    logic              w_try_start;

    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_word_cnt_nxt   = r_word_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_dai_nxt        = 1'b0;
        w_den_nxt        = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_underrun_nxt   = r_underrun;
        w_pop            = 1'b0;
        w_try_start      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_try_start = 1'b1;
            end

            ST_SHIFT: begin
                if (r_bit_cnt != c_BIT_LAST) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_dai_nxt     = r_shift[0];
                    w_den_nxt     = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    // Registered so the pulse lines up with the last bit on DAI.
                    w_frame_done_nxt = (r_bit_cnt == c_BIT_PEN) &&
                                       (r_word_cnt == c_WORD_LAST);
                end else if (r_word_cnt == c_WORD_LAST) begin
                    // Frame boundary: never flags underrun.
                    w_word_cnt_nxt = '0;
                    if (FRAME_GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_try_start = 1'b1;
                    end
                end else begin
                    w_word_cnt_nxt = r_word_cnt + 10'd1;
                    w_try_start    = 1'b1;
                    if (bus.enable && w_empty) begin
                        w_underrun_nxt = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_try_start = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Shared word-start rule: back-to-back words leave DEN high.
        if (w_try_start) begin
            if (bus.enable && !w_empty) begin
                w_pop         = 1'b1;
                w_shift_nxt   = w_head[WORD_W-1:1];
                w_dai_nxt     = w_head[0];
                w_den_nxt     = 1'b1;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = ST_SHIFT;
            end else begin
                w_state_nxt   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_dai        <= 1'b0;
            r_den        <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_dai        <= w_dai_nxt;
            r_den        <= w_den_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign bus.DAI        = r_dai;
    assign bus.DEN        = r_den;
    assign bus.frame_done = r_frame_done;
    assign bus.underrun   = r_underrun;
    assign bus.word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_leddc_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_leddc_serial_tx
// Description : Self-checking bench for leddc_serial_tx. Stimulus pushes the
//               expected words into a queue on acceptance; a monitor rebuilds
//               words from DAI/DEN and compares them, plus word_cnt and
//               frame_done, against its own frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leddc_serial_tx;

    logic DCK   = 1'b0;
    logic rst_n = 1'b0;

    leddc_serial_tx_if #(.WORD_W(16)) bus ();

    leddc_serial_tx #(
        .WORD_W      (16),
        .FRAME_WORDS (512),
        .FRAME_GAP   (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .DCK   (DCK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 DCK = ~DCK;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          words_done = 0;
    logic [15:0] exp_q [$];
    bit          src_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Drives a word from the negedge and returns right after the accepting posedge.
    task automatic push_word(input logic [15:0] w);
        int t;
        t = 0;
        @(negedge DCK);
        bus.pix_data  = w;
        bus.pix_valid = 1'b1;
        while (!bus.pix_ready) begin
            @(negedge DCK);
            t++;
            if (t > 2000) begin
                fail_now("push_timeout");
                return;
            end
        end
        @(posedge DCK);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge DCK);
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.enable    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge DCK);
        rst_n = 1'b1;
        @(negedge DCK);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !bus.DEN) break;
            @(negedge DCK);
        end
        if (i >= budget) fail_now(name);
    endtask

    task automatic wait_den(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (bus.DEN) break;
            @(negedge DCK);
        end
        if (i >= budget) fail_now(name);
    endtask

    // Monitor / scoreboard
    initial begin
        int          nbits;
        int          model_wc;
        logic [15:0] acc;
        logic        fd_exp;
        nbits    = 0;
        model_wc = 0;
        acc      = '0;
        forever begin
            @(negedge DCK);
            if (!rst_n) begin
                nbits    = 0;
                model_wc = 0;
            end else begin
                fd_exp = bus.DEN && (nbits == 15) && (model_wc == 511);
                if (fd_exp || bus.frame_done) chk("frame_done", bus.frame_done, fd_exp);
                if (bus.DEN) begin
                    if (nbits == 0) chk("word_cnt_at_start", bus.word_cnt, model_wc);
                    acc[nbits] = bus.DAI;
                    nbits++;
                    if (nbits == 16) begin
                        if (exp_q.size() == 0) fail_now("unexpected_word");
                        else chk("word_data", acc, exp_q.pop_front());
                        nbits = 0;
                        words_done++;
                        model_wc = (model_wc == 511) ? 0 : model_wc + 1;
                    end
                end else if (nbits != 0) begin
                    fail_now("den_pulse_short");
                    nbits = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cap;
        bit          den_ok;
        int          run;
        int          gap;
        int          i;
        int          base;
        logic        last_ur;
        logic        seen;

        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
        bus.enable    = 1'b0;

        // Reset state
        repeat (3) @(negedge DCK);
        chk("rst_den",        bus.DEN,        1'b0);
        chk("rst_dai",        bus.DAI,        1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_underrun",   bus.underrun,   1'b0);
        chk("rst_word_cnt",   bus.word_cnt,   10'd0);
        chk("rst_pix_ready",  bus.pix_ready,  1'b0);
        rst_n = 1'b1;
        @(negedge DCK);
        chk("post_rst_pix_ready", bus.pix_ready, 1'b1);

        // 1: single word, latency and bit order
        bus.enable = 1'b1;
        push_word(16'hA5C3);
        @(negedge DCK);
        bus.pix_valid = 1'b0;
        chk("t1_latency_den_low", bus.DEN, 1'b0);
        den_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge DCK);
            if (!bus.DEN) den_ok = 1'b0;
            cap[k] = bus.DAI;
        end
        chk("t1_den_16", den_ok, 1'b1);
        chk("t1_bits", cap, 16'hA5C3);
        @(negedge DCK);
        chk("t1_den_end", bus.DEN, 1'b0);
        chk("t1_word_cnt", bus.word_cnt, 10'd1);

        // 2: three pre-buffered words -> 48 contiguous DEN cycles
        do_reset();
        push_word(16'h1234);
        push_word(16'hBEEF);
        push_word(16'h0F0F);
        @(negedge DCK);
        bus.pix_valid = 1'b0;
        chk("t2_den_while_disabled", bus.DEN, 1'b0);
        bus.enable = 1'b1;
        wait_den("t2_den_timeout", 10);
        run = 0;
        last_ur = 1'b0;
        while (bus.DEN && run < 100) begin
            run++;
            last_ur = bus.underrun;
            @(negedge DCK);
        end
        chk("t2_den_run", run, 48);
        chk("t2_underrun_during", last_ur, 1'b0);
        chk("t2_underrun_after_empty", bus.underrun, 1'b1);
        wait_drain("t2_drain_timeout", 50);

        // 3: full frame with FIFO kept full
        do_reset();
        bus.enable = 1'b1;
        src_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 516; k++) push_word(16'(k * 40503 + 7));
                @(negedge DCK);
                bus.pix_valid = 1'b0;
                src_done = 1'b1;
            end
        join_none
        for (i = 0; i < 9000; i++) begin
            if (bus.frame_done) break;
            @(negedge DCK);
        end
        seen = bus.frame_done;
        chk("t3_frame_done_seen", seen, 1'b1);
        chk("t3_den_at_frame_done", bus.DEN, 1'b1);
        @(negedge DCK);
        chk("t3_frame_done_single", bus.frame_done, 1'b0);
        chk("t3_word_cnt_wrap", bus.word_cnt, 10'd0);
        gap = 0;
        while (!bus.DEN && gap < 20) begin
            gap++;
            @(negedge DCK);
        end
        chk("t3_gap_len", gap, 4);
        chk("t3_underrun", bus.underrun, 1'b0);
        for (i = 0; i < 500 && !src_done; i++) @(negedge DCK);
        if (!src_done) fail_now("t3_source_timeout");
        wait_drain("t3_drain_timeout", 200);

        // 4: source stalls after word index 10 -> underrun, resume at 11
        do_reset();
        bus.enable = 1'b1;
        for (int k = 0; k < 11; k++) push_word(16'h4000 + 16'(k));
        @(negedge DCK);
        bus.pix_valid = 1'b0;
        wait_drain("t4_drain_timeout", 400);
        chk("t4_underrun_set", bus.underrun, 1'b1);
        chk("t4_word_cnt_hold", bus.word_cnt, 10'd11);
        repeat (5) @(negedge DCK);
        chk("t4_underrun_sticky", bus.underrun, 1'b1);
        push_word(16'h7777);
        @(negedge DCK);
        bus.pix_valid = 1'b0;
        wait_den("t4_resume_timeout", 10);
        chk("t4_resume_word_cnt", bus.word_cnt, 10'd11);
        wait_drain("t4_drain2_timeout", 50);
        chk("t4_underrun_still", bus.underrun, 1'b1);

        // 5: disabled with five words offered -> four accepted, then all five sent
        do_reset();
        base = words_done;
        src_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) push_word(16'hC000 + 16'(k * 16'h0111));
                @(negedge DCK);
                bus.pix_valid = 1'b0;
                src_done = 1'b1;
            end
        join_none
        repeat (12) @(negedge DCK);
        chk("t5_pix_ready_full", bus.pix_ready, 1'b0);
        chk("t5_den_disabled", bus.DEN, 1'b0);
        chk("t5_accepted", exp_q.size(), 4);
        bus.enable = 1'b1;
        for (i = 0; i < 200 && !src_done; i++) @(negedge DCK);
        if (!src_done) fail_now("t5_source_timeout");
        wait_drain("t5_drain_timeout", 200);
        chk("t5_words_emitted", words_done - base, 5);

        // 6: reset at bit 7 with two words still buffered
        do_reset();
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        @(negedge DCK);
        bus.pix_valid = 1'b0;
        bus.enable = 1'b1;
        wait_den("t6_den_timeout", 10);
        repeat (7) @(negedge DCK);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge DCK);
        chk("t6_den_after_rst", bus.DEN, 1'b0);
        chk("t6_pix_ready_in_rst", bus.pix_ready, 1'b0);
        chk("t6_word_cnt", bus.word_cnt, 10'd0);
        chk("t6_underrun", bus.underrun, 1'b0);
        rst_n = 1'b1;
        @(negedge DCK);
        chk("t6_pix_ready_after", bus.pix_ready, 1'b1);
        den_ok = 1'b0;
        repeat (6) begin
            @(negedge DCK);
            if (bus.DEN) den_ok = 1'b1;
        end
        chk("t6_fifo_flushed", den_ok, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
